// File: rtl/psum_drain_pkg.sv
// rtl/psum_drain_pkg.sv - constants, FSM encoding and lane requantizer for psum_drain_writer
// Defining PSUM_DRAIN_RELU_EN clamps negative lanes to zero before rounding.
package psum_drain_pkg;

  localparam int DATA_W     = 16;
  localparam int OUT_W      = 8;
  localparam int LANES      = 512 / DATA_W;
  localparam int OUT_WORD_W = LANES * OUT_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_HALT  = 3'd4
  } drain_state_t;

  localparam logic signed [DATA_W:0] SAT_HI = 17'sd127;
  localparam logic signed [DATA_W:0] SAT_LO = -17'sd128;

  // One extra bit keeps x + rounding bias from wrapping near +32767.
  function automatic logic [OUT_W-1:0] requant(input logic signed [DATA_W-1:0] x,
                                                input logic [3:0] s);
    logic signed [DATA_W:0] v;
    v = {x[DATA_W-1], x};
`ifdef PSUM_DRAIN_RELU_EN
    if (x[DATA_W-1]) v = '0;
`endif
    if (s != 4'd0) v = v + (17'sd1 <<< (s - 4'd1));
    v = v >>> s;
    if (v > SAT_HI)      requant = 8'h7F;
    else if (v < SAT_LO) requant = 8'h80;
    else                 requant = v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/psum_drain_fifo.sv
// rtl/psum_drain_fifo.sv - synchronous capture FIFO (power-of-2 depth) with async active-high reset
module psum_drain_fifo #(
  parameter int WIDTH = 261,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[PW-1:0]] <= i_wdata;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/psum_drain_writer.sv
// rtl/psum_drain_writer.sv - requantizes psum GBF drain words and writes them to output SRAM
// Optional PSUM_DRAIN_RELU_EN fuses a ReLU into the requantizer.
module psum_drain_writer
  import psum_drain_pkg::*;
#(
  parameter int DATA_BITWIDTH      = 16,
  parameter int GBF_DATA_BITWIDTH  = 512,
  parameter int OUT_BITWIDTH       = 8,
  parameter int GBF_ADDR_BITWIDTH  = 5,
  parameter int SRAM_ADDR_BITWIDTH = 16,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_psum_gbf_r_en,
  input  logic [GBF_ADDR_BITWIDTH-1:0]         i_psum_gbf_r_addr,
  input  logic [GBF_DATA_BITWIDTH-1:0]         i_psum_gbf_r_data,
  input  logic                                 i_conv_finish,
  input  logic [3:0]                           i_shift_amt,
  input  logic [SRAM_ADDR_BITWIDTH-1:0]        i_base_addr,
  output logic                                 o_sram_w_valid,
  input  logic                                 i_sram_w_ready,
  output logic [SRAM_ADDR_BITWIDTH-1:0]        o_sram_w_addr,
  output logic [(GBF_DATA_BITWIDTH/DATA_BITWIDTH)*OUT_BITWIDTH-1:0] o_sram_w_data,
  output logic                                 o_drain_done,
  output logic                                 o_all_done,
  output logic                                 o_overflow_err
);

  localparam int LN     = GBF_DATA_BITWIDTH / DATA_BITWIDTH;
  localparam int OWW    = LN * OUT_BITWIDTH;
  localparam int DEPTH  = 1 << GBF_ADDR_BITWIDTH;
  localparam int TILE_W = SRAM_ADDR_BITWIDTH - GBF_ADDR_BITWIDTH;
  localparam int FW     = OWW + GBF_ADDR_BITWIDTH;
  localparam logic [GBF_ADDR_BITWIDTH:0] LAST_WORD = (GBF_ADDR_BITWIDTH+1)'(DEPTH - 1);

  drain_state_t                    r_state;
  drain_state_t                    w_next_state;
  logic                            r_pend;
  logic [GBF_ADDR_BITWIDTH-1:0]    r_pend_addr;
  logic                            r_cap_valid;
  logic [GBF_ADDR_BITWIDTH-1:0]    r_cap_addr;
  logic [GBF_DATA_BITWIDTH-1:0]    r_cap_data;
  logic [GBF_ADDR_BITWIDTH:0]      r_word_cnt;
  logic [TILE_W-1:0]               r_tile_cnt;
  logic [SRAM_ADDR_BITWIDTH-1:0]   r_base;
  logic [3:0]                      r_shift;
  logic                            r_overflow;

  logic                            w_accept;
  logic                            w_capture;
  logic                            w_pop;
  logic                            w_drop;
  logic                            w_fifo_full;
  logic                            w_fifo_empty;
  logic [OWW-1:0]                  w_quant;
  logic [FW-1:0]                   w_head;
  logic [GBF_ADDR_BITWIDTH-1:0]    w_head_idx;

  // Read requests are only honoured while a drain can still absorb them.
  assign w_accept  = (r_state == ST_IDLE) || (r_state == ST_DRAIN);
  assign w_capture = r_pend && (r_state == ST_DRAIN);
  assign w_pop     = o_sram_w_valid && i_sram_w_ready;
  assign w_drop    = r_cap_valid && w_fifo_full && !w_pop;

  always_comb begin
    w_quant = '0;
    for (int i = 0; i < LN; i++) begin
      w_quant[i*OUT_BITWIDTH +: OUT_BITWIDTH] =
        requant(r_cap_data[i*DATA_BITWIDTH +: DATA_BITWIDTH], r_shift);
    end
  end

  psum_drain_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_cap_valid),
    .i_wdata ({r_cap_addr, w_quant}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_head_idx     = w_head[FW-1 -: GBF_ADDR_BITWIDTH];
  assign o_sram_w_valid = !w_fifo_empty;
  assign o_sram_w_data  = w_head[OWW-1:0];
  assign o_sram_w_addr  = r_base + {r_tile_cnt, w_head_idx};
  assign o_drain_done   = (r_state == ST_DONE);
  assign o_all_done     = (r_state == ST_HALT);
  assign o_overflow_err = r_overflow;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_psum_gbf_r_en)    w_next_state = ST_DRAIN;
        else if (i_conv_finish) w_next_state = ST_HALT;
      end
      ST_DRAIN: if (w_capture && (r_word_cnt == LAST_WORD)) w_next_state = ST_FLUSH;
      // The final capture is still in the capture register for one cycle.
      ST_FLUSH: if (w_fifo_empty && !r_cap_valid) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = i_conv_finish ? ST_HALT : ST_IDLE;
      ST_HALT:  w_next_state = ST_HALT;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_cap_valid <= 1'b0;
      r_cap_addr  <= '0;
      r_cap_data  <= '0;
      r_word_cnt  <= '0;
      r_tile_cnt  <= '0;
      r_base      <= '0;
      r_shift     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pend      <= i_psum_gbf_r_en && w_accept;
      if (i_psum_gbf_r_en && w_accept) r_pend_addr <= i_psum_gbf_r_addr;
      r_cap_valid <= w_capture;
      if (w_capture) begin
        r_cap_addr <= r_pend_addr;
        r_cap_data <= i_psum_gbf_r_data;
      end
      if ((r_state == ST_IDLE) && i_psum_gbf_r_en) begin
        r_base  <= i_base_addr;
        r_shift <= i_shift_amt;
      end
      if (r_state == ST_DONE) begin
        r_word_cnt <= '0;
        r_tile_cnt <= r_tile_cnt + 1'b1;
      end else if (w_capture) begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_drain_writer.sv
// tb/tb_psum_drain_writer.sv - directed self-checking bench for psum_drain_writer
module tb_psum_drain_writer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         r_en = 1'b0;
  logic [4:0]   r_addr = '0;
  logic [511:0] r_data = '0;
  logic         conv_finish = 1'b0;
  logic [3:0]   shift_amt = 4'd2;
  logic [15:0]  base_addr = '0;
  logic         w_valid;
  logic         w_ready = 1'b1;
  logic [15:0]  w_addr;
  logic [255:0] w_data;
  logic         drain_done;
  logic         all_done;
  logic         overflow_err;

  logic [511:0] gbf [32];
  logic [15:0]  wr_addr [$];
  logic [255:0] wr_data [$];
  int           done_cnt = 0;
  int           n_pass = 0;
  int           n_total = 0;
  logic         tog = 1'b0;
  logic         prev_stall = 1'b0;
  logic [15:0]  prev_addr;
  logic [255:0] prev_data;

  psum_drain_writer dut (
    .clk               (clk),
    .reset             (reset),
    .i_psum_gbf_r_en   (r_en),
    .i_psum_gbf_r_addr (r_addr),
    .i_psum_gbf_r_data (r_data),
    .i_conv_finish     (conv_finish),
    .i_shift_amt       (shift_amt),
    .i_base_addr       (base_addr),
    .o_sram_w_valid    (w_valid),
    .i_sram_w_ready    (w_ready),
    .o_sram_w_addr     (w_addr),
    .o_sram_w_data     (w_data),
    .o_drain_done      (drain_done),
    .o_all_done        (all_done),
    .o_overflow_err    (overflow_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (r_en) r_data <= gbf[r_addr];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && w_valid) begin
        chk("hold_addr", 256'(w_addr), 256'(prev_addr));
        chk("hold_data", w_data, prev_data);
      end
      prev_stall = w_valid && !w_ready;
      prev_addr  = w_addr;
      prev_data  = w_data;
      if (w_valid && w_ready) begin
        wr_addr.push_back(w_addr);
        wr_data.push_back(w_data);
      end
      if (drain_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) w_ready = ~w_ready;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    r_en = 1'b0;
    conv_finish = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic issue(input int a, input int gap);
    r_en = 1'b1;
    r_addr = 5'(a);
    tick();
    r_en = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic drain(input int n, input int gap, input int cf_at);
    for (int i = 0; i < n; i++) begin
      if (i == cf_at) conv_finish = 1'b1;
      issue(i, gap);
    end
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 400 && done_cnt < target; k++) tick();
    chk("drain_done_cnt", 256'(done_cnt), 256'(target));
  endtask

  function automatic logic [255:0] rep(input int v);
    logic [255:0] r;
    for (int l = 0; l < 32; l++) r[l*8 +: 8] = 8'(v);
    return r;
  endfunction

  task automatic fill_ramp();
    for (int a = 0; a < 32; a++)
      for (int l = 0; l < 32; l++) gbf[a][l*16 +: 16] = 16'(a * 4);
  endtask

  task automatic check_writes(input int first, input int n, input logic [15:0] abase);
    logic [15:0]  ga;
    logic [255:0] gd;
    for (int i = 0; i < n; i++) begin
      ga = (first + i < wr_addr.size()) ? wr_addr[first+i] : 16'hFFFF;
      gd = (first + i < wr_data.size()) ? wr_data[first+i] : '1;
      chk($sformatf("wr_addr[%0d]", first + i), 256'(ga), 256'(abase + 16'(i)));
      chk($sformatf("wr_data[%0d]", first + i), gd, rep(i));
    end
  endtask

  initial begin
    logic [255:0] exp2;

    // 1: reset state, then a paced drain with lane = 4*addr, s=2
    fill_ramp();
    base_addr = 16'h0040;
    do_reset();
    chk("rst_valid", 256'(w_valid), 256'(0));
    chk("rst_done", 256'(drain_done), 256'(0));
    chk("rst_all_done", 256'(all_done), 256'(0));
    chk("rst_overflow", 256'(overflow_err), 256'(0));
    chk("rst_data", w_data, 256'(0));
    drain(32, 1, -1);
    wait_done(1);
    repeat (4) tick();
    chk("t1_nwrites", 256'(wr_addr.size()), 256'(32));
    check_writes(0, 32, 16'h0040);
    chk("t1_done_once", 256'(done_cnt), 256'(1));
    chk("t1_overflow", 256'(overflow_err), 256'(0));

    // 2: saturation and rounding corners
    for (int a = 0; a < 32; a++) begin
      gbf[a] = '0;
      gbf[a][15:0]  = 16'h7FFF;
      gbf[a][31:16] = 16'h8000;
      gbf[a][47:32] = 16'h0006;
    end
    exp2 = '0;
    exp2[7:0] = 8'h7F;
`ifdef PSUM_DRAIN_RELU_EN
    exp2[15:8] = 8'h00;
`else
    exp2[15:8] = 8'h80;
`endif
    exp2[23:16] = 8'h02;
    base_addr = 16'h0000;
    do_reset();
    drain(32, 1, -1);
    wait_done(1);
    chk("t2_nwrites", 256'(wr_data.size()), 256'(32));
    chk("t2_word_first", (wr_data.size() > 0) ? wr_data[0] : '1, exp2);
    chk("t2_word_last", (wr_data.size() > 31) ? wr_data[31] : '1, exp2);

    // 3: no ready for a whole drain -> four words kept, the rest dropped
    fill_ramp();
    base_addr = 16'h0080;
    do_reset();
    w_ready = 1'b0;
    drain(32, 0, -1);
    repeat (12) tick();
    chk("t3_overflow", 256'(overflow_err), 256'(1));
    chk("t3_no_done_yet", 256'(done_cnt), 256'(0));
    chk("t3_valid_held", 256'(w_valid), 256'(1));
    w_ready = 1'b1;
    wait_done(1);
    chk("t3_nwrites", 256'(wr_addr.size()), 256'(4));
    check_writes(0, 4, 16'h0080);
    chk("t3_overflow_sticky", 256'(overflow_err), 256'(1));

    // 4: ready toggling every cycle, one request every other cycle
    base_addr = 16'h0010;
    do_reset();
    tog = 1'b1;
    drain(32, 1, -1);
    wait_done(1);
    tog = 1'b0;
    w_ready = 1'b1;
    chk("t4_nwrites", 256'(wr_addr.size()), 256'(32));
    check_writes(0, 32, 16'h0010);
    chk("t4_overflow", 256'(overflow_err), 256'(0));

    // 5: two drains, conv_finish raised during the second -> HALT
    base_addr = 16'h0100;
    do_reset();
    drain(32, 1, -1);
    wait_done(1);
    repeat (2) tick();
    chk("t5_not_halted", 256'(all_done), 256'(0));
    drain(32, 1, 5);
    wait_done(2);
    tick();
    chk("t5_all_done", 256'(all_done), 256'(1));
    chk("t5_nwrites", 256'(wr_addr.size()), 256'(64));
    check_writes(0, 32, 16'h0100);
    check_writes(32, 32, 16'h0120);
    issue(3, 8);
    chk("t5_halt_ignores_ren", 256'(wr_addr.size()), 256'(64));
    chk("t5_halt_sticky", 256'(all_done), 256'(1));

    // 6: reset during the second drain -> outputs cleared, tile count restarts
    base_addr = 16'h0300;
    do_reset();
    drain(32, 1, -1);
    wait_done(1);
    repeat (2) tick();
    drain(10, 1, -1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", 256'(w_valid), 256'(0));
    chk("t6_rst_addr", 256'(w_addr), 256'(0));
    chk("t6_rst_data", w_data, 256'(0));
    chk("t6_rst_done", 256'(drain_done), 256'(0));
    do_reset();
    drain(32, 1, -1);
    wait_done(1);
    chk("t6_nwrites", 256'(wr_addr.size()), 256'(32));
    check_writes(0, 32, 16'h0300);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
